// File: rtl/shift_register_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_register_pkg
//  Description : Shared types and defaults for the universal shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_register_pkg;

    // Operation select carried on the 2-bit ctrl port
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_SHL  = 2'd1,
        OP_SHR  = 2'd2,
        OP_LOAD = 2'd3
    } shift_op_e;

    // Default register width
    localparam int SHREG_N_DEFAULT = 8;

endpackage : shift_register_pkg
`default_nettype wire

// File: rtl/shift_next_state.sv
`default_nettype none
// ============================================================================
//  Module      : shift_next_state
//  Description : Purely combinational next-state function of the universal
//                shift register (hold / shift left / shift right / load).
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_next_state
    import shift_register_pkg::*;
#(
    parameter int N = SHREG_N_DEFAULT
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] data,
    input  shift_op_e    op,
    output logic [N-1:0] q_next
);

    // Select the next register value; shifts drop the outgoing bit and take
    // the incoming bit from the data edge bit nearest the vacated position
    always_comb begin
        q_next = q;
        case (op)
            OP_HOLD: q_next = q;
            OP_SHL:  q_next = {q[N-2:0], data[0]};
            OP_SHR:  q_next = {data[N-1], q[N-1:1]};
            OP_LOAD: q_next = data;
            default: q_next = q;
        endcase
    end

endmodule : shift_next_state
`default_nettype wire

// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : universal_shift_register
//  Description : N-bit universal shift register with registered parallel
//                output. Synchronous active-low reset has priority over ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_register
    import shift_register_pkg::*;
#(
    parameter int N = SHREG_N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   ctrl,
    input  logic [N-1:0] data,
    output logic [N-1:0] q_reg
);

    logic [N-1:0] shreg_q;
    logic [N-1:0] shreg_d;
    logic [N-1:0] w_q_next;
    shift_op_e    w_op;

    // Width below 2 leaves no room for a shift
    if (N < 2) begin : g_bad_width
        $error("universal_shift_register: N must be >= 2");
    end

    // Port carries a plain 2-bit vector; the datapath works on the enum
    assign w_op = shift_op_e'(ctrl);

    shift_next_state #(
        .N (N)
    ) u_next (
        .q      (shreg_q),
        .data   (data),
        .op     (w_op),
        .q_next (w_q_next)
    );

    // Reset mux in front of the register: reset wins over any operation
    always_comb begin
        shreg_d = w_q_next;
        if (!reset) begin
            shreg_d = '0;
        end
    end

    // Single state register; q_reg is taken straight from it
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign q_reg = shreg_q;

`ifndef SYNTHESIS
    // Register is cleared after every edge that sees reset low
    a_reset_clears : assert property (@(posedge clk) !reset |=> (q_reg == '0))
        else $error("q_reg not cleared after reset edge");

    // Hold leaves the register untouched
    a_hold_stable : assert property (@(posedge clk)
        (reset && (ctrl == 2'b00)) |=> $stable(q_reg))
        else $error("q_reg changed during hold");
`endif

endmodule : universal_shift_register
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_universal_shift_register
//  Description : Self-checking bench for universal_shift_register (N=8):
//                directed vector table plus random stimulus against a
//                behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

    localparam int N = 8;

    typedef struct {
        logic       rst_n;
        logic [1:0] ctrl;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [7:0] q_reg;

    int checks;
    int failures;
    logic [7:0] model;
    vec_t vecs[$];

    universal_shift_register #(
        .N (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl),
        .data  (data),
        .q_reg (q_reg)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: arithmetic on the integer value of the register
    function automatic logic [7:0] ref_next(logic [7:0] cur, logic r, logic [1:0] c, logic [7:0] d);
        int v;
        if (!r) return 8'h00;
        v = int'(cur);
        case (c)
            2'd1:    v = ((v * 2) % 256) + int'(d[0]);
            2'd2:    v = (v / 2) + (d[7] ? 128 : 0);
            2'd3:    v = int'(d);
            default: v = int'(cur);
        endcase
        return 8'(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge happen, sample on the next falling edge
    task automatic step(input logic r, input logic [1:0] c, input logic [7:0] d);
        reset = r;
        ctrl  = c;
        data  = d;
        @(posedge clk);
        model = ref_next(model, r, c, d);
        @(negedge clk);
    endtask

    function automatic void add(input logic r, input logic [1:0] c, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.rst_n = r; v.ctrl = c; v.data = d; v.exp = e;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] rd;
        logic [7:0] sl_exp [10];
        logic [7:0] sr_exp [10];
        checks   = 0;
        failures = 0;
        model    = 8'h00;
        reset    = 1'b0;
        ctrl     = 2'b00;
        data     = 8'h00;

        // Directed sequences, one row per rising edge
        add(1, 2'd3, 8'h55, 8'h55);
        for (int i = 0; i < 5; i++) add(1, 2'd0, 8'hFF, 8'h55);
        sl_exp = '{8'hAA, 8'h54, 8'hA8, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) add(1, 2'd1, 8'hAA, sl_exp[i]);
        add(1, 2'd3, 8'h80, 8'h80);
        add(1, 2'd1, 8'h01, 8'h01);
        add(1, 2'd3, 8'hF0, 8'hF0);
        add(1, 2'd2, 8'h0F, 8'h78);
        add(1, 2'd2, 8'h0F, 8'h3C);
        add(1, 2'd3, 8'h01, 8'h01);
        add(1, 2'd2, 8'h80, 8'h80);
        sr_exp = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) add(1, 2'd2, 8'h0F, sr_exp[i]);
        // Reset in the middle of a shift-left run
        add(1, 2'd3, 8'hFF, 8'hFF);
        add(1, 2'd1, 8'h01, 8'hFF);
        add(0, 2'd1, 8'h01, 8'h00);
        add(1, 2'd1, 8'h01, 8'h01);
        add(1, 2'd1, 8'h00, 8'h02);

        @(negedge clk);

        // Reset held for 20 cycles with random ctrl/data
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
            check("reset_hold", q_reg, 8'h00);
        end
        step(1'b1, 2'd0, 8'($urandom));
        check("reset_release", q_reg, 8'h00);

        // Directed vector table
        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].ctrl, vecs[i].data);
            check($sformatf("vec%0d", i), q_reg, vecs[i].exp);
        end

        // Random load sweep, each value held for two edges
        for (int i = 0; i < 100; i++) begin
            rd = 8'($urandom);
            step(1'b1, 2'd3, rd);
            check("load_sweep_a", q_reg, model);
            check("load_sweep_data", q_reg, rd);
            step(1'b1, 2'd3, rd);
            check("load_sweep_b", q_reg, model);
        end

        // Random mix of all operations with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
            check("random_mix", q_reg, model);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not finish, failures=%0d", failures);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_universal_shift_register
`default_nettype wire

// File: doc/universal_shift_register.md
# universal_shift_register

N-bit universal shift register with a registered parallel output. A 2-bit control selects one of four operations each clock: hold, shift left, shift right, or parallel load. It is a small datapath leaf, used standalone and as the golden model against the fabric post-route netlist of the same function.

## Interface
Parameters:
- `N`, default 8: register width in bits; must be ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-low reset. It is sampled on the rising edge of `clk`; `reset`=0 clears the register.
- `ctrl`, input, 2: operation select, sampled every rising edge.
- `data`, input, N: parallel-load value and serial-in source bits.
- `q_reg`, output, N: current register contents, driven directly from flops with no combinational path from the inputs.

## Operation
- Exactly one N-bit state register exists, and `q_reg` is that register.
- On each rising edge, `reset`=0 takes priority: the next state is all zeros, regardless of `ctrl` and `data`.
- When `reset`=1, the next state depends on `ctrl`:
  - `2'b00`, hold: `q_reg` is unchanged.
  - `2'b01`, shift left: next = {`q_reg`[N-2:0], `data`[0]}. The MSB is discarded and `data`[0] enters the LSB.
  - `2'b10`, shift right: next = {`data`[N-1], `q_reg`[N-1:1]}. The LSB is discarded and `data`[N-1] enters the MSB.
  - `2'b11`, load: next = `data`.
- Only the bit named for each operation is used: `data`[0] for shift left, `data`[N-1] for shift right, and all of `data` for load. Other `data` bits are ignored in each mode.
- No undefined `ctrl` encodings exist. X/Z on `ctrl` in simulation need not be handled specially.
- No wrap-around or rotate: bits shifted out are lost.

## Timing
- Latency is 1 cycle. Inputs present at rising edge k appear on `q_reg` immediately after edge k.
- One operation per cycle. Consecutive shifts accumulate, one bit position per edge.
- Reset value of `q_reg` is 0. Before the first active reset edge the state is undefined.
- Reset mid-operation: if `reset`=0 at any edge, `q_reg` is 0 after that edge, discarding any in-progress shift or load. Normal operation resumes on the first edge with `reset`=1.
- When `reset`=1 and `ctrl`=`2'b00`, `q_reg` is stable indefinitely.
- Inputs must meet setup/hold relative to the rising edge of `clk`. The bench changes stimulus on the falling edge and checks on the falling edge.

## Structure
- The shared package `shift_register_pkg` holds:
  - an enum `shift_op_e` with `OP_HOLD`=0, `OP_SHL`=1, `OP_SHR`=2, `OP_LOAD`=3;
  - a default-width localparam `SHREG_N_DEFAULT`=8.
- `ctrl` is typed as `logic [1:0]` at the port and cast to `shift_op_e` internally.
- Optional sub-module `shift_next_state` is purely combinational. Its inputs are `q`, `data` and `op`; its output is `q_next`. The top level contains only the reset mux and the flop.
- Add assertions (simulation only):
  - after any edge with `reset`=0, `q_reg`==0;
  - for `OP_HOLD`, `$stable(q_reg)`.

## Test plan
With N=8:
- **Reset:** hold `reset`=0 for 20 cycles with random `ctrl`/`data`, then release → `q_reg`=0x00 throughout and one cycle after release (with `ctrl`=`2'b00`).
- **Load then hold:** `ctrl`=3, `data`=0x55 for one edge → `q_reg`=0x55. Then `ctrl`=0 with `data`=0xFF for 5 edges → `q_reg` stays 0x55.
- **Shift left:** from 0x55, `ctrl`=1, `data`=0xAA (`data`[0]=0) → 0xAA, then 0x54, then 0xA8. After 10 edges the result is 0x00. With `data`=0x01, from 0x80 one edge → 0x01.
- **Shift right:** load 0xF0, then `ctrl`=2, `data`=0x0F (`data`[7]=0) → 0x78, then 0x3C. With `data`=0x80 from 0x01 → 0x80. After 10 edges with `data`=0x0F the result is 0x00.
- **Random load sweep:** 100 iterations of `ctrl`=3 with random `data` held for 2 edges → `q_reg` equals that `data` after each. Compare against the reference model and against the post-route netlist, with zero mismatches.
- **Reset mid-shift:** during a shift-left sequence from 0xFF with `data`=0x01, assert `reset`=0 for one edge → `q_reg`=0x00. The next shift edge gives 0x01.
